// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // High half of the accumulator holds the MULH* product bits and the remainder.
  function automatic logic sel_high(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  // The partial remainder stays below the divisor, so bit XLEN of diff is a clean borrow.
  assign diff    = shifted - {1'b0, divisor};
  assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: magnitude shift-add / restoring divide over XLEN
// cycles, then a sign-fix stage and a held result with valid/ready handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_reg;
  muldiv_op_e      op_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0] opnd_reg;
  logic [XLEN-1:0] special_reg;
  logic [XLEN-1:0] result_reg;
  logic [CW-1:0]   cnt_reg;
  logic            neg_lo_reg;
  logic            neg_hi_reg;
  logic            special_flag_reg;
  logic            fix_phase_reg;

  muldiv_op_e      op_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;
  logic            accept;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN-1:0] div_rem, div_quo;

  assign op_in    = muldiv_op_e'(op);
  assign a_neg    = is_signed_a(op_in) && a[XLEN-1];
  assign b_neg    = is_signed_b(op_in) && b[XLEN-1];
  assign a_abs    = a_neg ? -a : a;
  assign b_abs    = b_neg ? -b : b;
  assign div_zero = is_div(op_in) && (b == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (a == MIN_VAL) && (b == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : a;
    else if (div_ovf)
      special_val = (op_in == OP_DIV) ? a : '0;
  end

  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign accept    = in_ready && in_valid && !kill;
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign result    = result_reg;

  // Multiplier bits sit in the low half and shift out as the product shifts in.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
                  + (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc_reg[2*XLEN-1:XLEN]),
    .quo_in  (acc_reg[XLEN-1:0]),
    .divisor (opnd_reg),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      op_reg           <= OP_MUL;
      acc_reg          <= '0;
      opnd_reg         <= '0;
      special_reg      <= '0;
      result_reg       <= '0;
      cnt_reg          <= '0;
      neg_lo_reg       <= 1'b0;
      neg_hi_reg       <= 1'b0;
      special_flag_reg <= 1'b0;
      fix_phase_reg    <= 1'b0;
    end else if (kill && state_reg != ST_IDLE) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg           <= op_in;
            opnd_reg         <= is_div(op_in) ? b_abs : a_abs;
            acc_reg          <= {{XLEN{1'b0}}, (is_div(op_in) ? a_abs : b_abs)};
            neg_lo_reg       <= a_neg ^ b_neg;
            neg_hi_reg       <= is_div(op_in) ? a_neg : (a_neg ^ b_neg);
            special_flag_reg <= special;
            special_reg      <= special_val;
            cnt_reg          <= CW'(XLEN-1);
            // Early-out enters the second FIX phase directly so the result lands one edge later.
            if (special && EARLY_OUT) begin
              state_reg     <= ST_FIX;
              fix_phase_reg <= 1'b1;
            end else begin
              state_reg     <= ST_CALC;
              fix_phase_reg <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          acc_reg <= is_div(op_reg) ? {div_rem, div_quo} : mul_next;
          if (cnt_reg == '0)
            state_reg <= ST_FIX;
          else
            cnt_reg <= cnt_reg - 1'b1;
        end
        ST_FIX: begin
          // Negate and field-select in separate cycles to keep the wide adder off the mux path.
          if (!fix_phase_reg) begin
            if (is_div(op_reg)) begin
              if (neg_hi_reg) acc_reg[2*XLEN-1:XLEN] <= -acc_reg[2*XLEN-1:XLEN];
              if (neg_lo_reg) acc_reg[XLEN-1:0]      <= -acc_reg[XLEN-1:0];
            end else if (neg_lo_reg) begin
              acc_reg <= -acc_reg;
            end
            fix_phase_reg <= 1'b1;
          end else begin
            if (special_flag_reg)
              result_reg <= special_reg;
            else if (sel_high(op_reg))
              result_reg <= acc_reg[2*XLEN-1:XLEN];
            else
              result_reg <= acc_reg[XLEN-1:0];
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench: two XLEN=32 units (EARLY_OUT 0 and 1) driven in lockstep, plus an XLEN=16 unit.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst, in_valid, kill, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [31:0] result0, result1;

  logic        in_valid16, out_ready16, in_ready16, out_valid16, busy16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, result16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .op(op), .a(a), .b(b),
    .kill(kill), .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .busy(busy0));

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op), .a(a), .b(b),
    .kill(kill), .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .busy(busy1));

  muldiv_unit #(.XLEN(16), .EARLY_OUT(1'b0)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16), .a(a16),
    .b(b16), .kill(kill), .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .busy(busy16));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat1;
    string       name;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op to both 32-bit units, measure latency, optionally stall, then consume.
  task automatic run_op(input logic [2:0] vop, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vexp, input int vlat1, input int stall,
                        input string name);
    int lat0, lat1;
    bit rdy_seen;
    lat0 = -1;
    lat1 = -1;
    rdy_seen = 1'b0;
    @(negedge clk);
    check({name, " in_ready"}, {30'd0, in_ready1, in_ready0}, 32'h3);
    in_valid = 1'b1; op = vop; a = va; b = vb;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    for (int c = 0; c < 60 && (lat0 < 0 || lat1 < 0); c++) begin
      @(negedge clk);
      if (out_valid0 && lat0 < 0) lat0 = c;
      if (out_valid1 && lat1 < 0) lat1 = c;
      if (in_ready0 || in_ready1) rdy_seen = 1'b1;
    end
    check({name, " lat EO0"}, 32'(lat0), 32'd34);
    check({name, " lat EO1"}, 32'(lat1), 32'(vlat1));
    check({name, " result EO0"}, result0, vexp);
    check({name, " result EO1"}, result1, vexp);
    check({name, " in_ready low while busy"}, {31'd0, rdy_seen}, 32'd0);
    if (stall > 0) begin
      in_valid = 1'b1; op = MUL; a = 32'd3; b = 32'd5;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check({name, " stall out_valid"}, {30'd0, out_valid1, out_valid0}, 32'h3);
        check({name, " stall result EO0"}, result0, vexp);
        check({name, " stall result EO1"}, result1, vexp);
        check({name, " stall in_ready"}, {30'd0, in_ready1, in_ready0}, 32'h0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, " consumed out_valid"}, {30'd0, out_valid1, out_valid0}, 32'h0);
    if (lat0 < 0 || lat1 < 0) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int lat16;
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

    vecs[0]  = '{MUL,    32'd7,          32'd6,          32'd42,         34, "MUL 7*6"};
    vecs[1]  = '{MUL,    32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   34, "MUL -1*2"};
    vecs[2]  = '{MULH,   32'h80000000,   32'h80000000,   32'h40000000,   34, "MULH min*min"};
    vecs[3]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   34, "MULHU max*max"};
    vecs[4]  = '{MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   34, "MULHSU -1*2"};
    vecs[5]  = '{MULH,   32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   34, "MULH -3*5"};
    vecs[6]  = '{DIV,    32'hFFFFFFEC,   32'd3,          32'hFFFFFFFA,   34, "DIV -20/3"};
    vecs[7]  = '{REM,    32'hFFFFFFEC,   32'd3,          32'hFFFFFFFE,   34, "REM -20/3"};
    vecs[8]  = '{DIVU,   32'd20,         32'd3,          32'd6,          34, "DIVU 20/3"};
    vecs[9]  = '{REMU,   32'd20,         32'd3,          32'd2,          34, "REMU 20/3"};
    vecs[10] = '{REM,    32'd20,         32'hFFFFFFFD,   32'd2,          34, "REM 20/-3"};
    vecs[11] = '{DIV,    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34, "DIV 7/-2"};
    vecs[12] = '{REM,    32'd7,          32'hFFFFFFFE,   32'd1,          34, "REM 7/-2"};
    vecs[13] = '{DIVU,   32'd5,          32'd0,          32'hFFFFFFFF,   1,  "DIVU 5/0"};
    vecs[14] = '{REM,    32'd5,          32'd0,          32'd5,          1,  "REM 5/0"};
    vecs[15] = '{DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  "DIV min/-1"};
    vecs[16] = '{REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  "REM min/-1"};
    vecs[17] = '{DIV,    32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1,  "DIV -7/0"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {29'd0, out_valid16, out_valid1, out_valid0}, 32'h0);
    check("reset busy", {29'd0, busy16, busy1, busy0}, 32'h0);
    check("reset in_ready", {29'd0, in_ready16, in_ready1, in_ready0}, 32'h0);
    check("reset result EO0", result0, 32'h0);
    check("reset result EO1", result1, 32'h0);
    rst = 1'b0;

    // kill together with in_valid in IDLE must not start an op
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; op = MUL; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill+in_valid no accept", {30'd0, busy1, busy0}, 32'h0);

    for (int i = 0; i < 18; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat1, 0, vecs[i].name);

    run_op(MUL, 32'd9, 32'd11, 32'd99, 34, 5, "stall MUL 9*11");
    $display("transaction: stall held 5 cycles in DONE");

    // kill at the tenth CALC cycle
    @(negedge clk);
    in_valid = 1'b1; op = DIVU; a = 32'd20; b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("pre-kill busy", {30'd0, busy1, busy0}, 32'h3);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("post-kill busy", {30'd0, busy1, busy0}, 32'h0);
    check("post-kill in_ready", {30'd0, in_ready1, in_ready0}, 32'h3);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) seen = 1'b1;
    end
    check("post-kill no out_valid", {31'd0, seen}, 32'd0);
    $display("transaction: kill at CALC cycle 10");

    // rst while in FIX drops the op and clears the result
    @(negedge clk);
    in_valid = 1'b1; op = MUL; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("pre-rst busy in FIX", {30'd0, busy1, busy0}, 32'h3);
    check("pre-rst out_valid", {30'd0, out_valid1, out_valid0}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst-in-FIX out_valid", {30'd0, out_valid1, out_valid0}, 32'h0);
    check("rst-in-FIX busy", {30'd0, busy1, busy0}, 32'h0);
    check("rst-in-FIX in_ready", {30'd0, in_ready1, in_ready0}, 32'h0);
    check("rst-in-FIX result EO0", result0, 32'h0);
    check("rst-in-FIX result EO1", result1, 32'h0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) seen = 1'b1;
    end
    check("post-rst no out_valid", {31'd0, seen}, 32'd0);
    check("post-rst in_ready", {30'd0, in_ready1, in_ready0}, 32'h3);
    $display("transaction: rst during FIX");

    // XLEN=16 overflow divide through the full FSM
    @(negedge clk);
    check("x16 in_ready", {31'd0, in_ready16}, 32'd1);
    in_valid16 = 1'b1; op16 = DIV; a16 = 16'h8000; b16 = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    lat16 = -1;
    for (int c = 0; c < 40 && lat16 < 0; c++) begin
      @(negedge clk);
      if (out_valid16) lat16 = c;
    end
    check("x16 DIV min/-1 latency", 32'(lat16), 32'd18);
    check("x16 DIV min/-1 result", {16'd0, result16}, 32'h8000);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    out_ready16 = 1'b0;
    $display("transaction: XLEN=16 DIV 0x8000/0xFFFF -> 0x%04h", result16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
